// File: rtl/hazard_unit_if.sv
// Pipeline hazard interface: the datapath fields the unit observes and the
// enables, flushes and statistics it drives back into the pipeline.
interface hazard_unit_if;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_write;
  logic        exmem_write;
  logic        ctrl_enable;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output idex_memread, idex_rt, ifid_rs, ifid_rt, branch_taken, mem_busy,
    input  pc_write, ifid_write, idex_write, exmem_write, ctrl_enable,
    input  ifid_flush, idex_flush, exmem_flush, stall_count, flush_count
  );

  modport slave (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt, branch_taken, mem_busy,
    output pc_write, ifid_write, idex_write, exmem_write, ctrl_enable,
    output ifid_flush, idex_flush, exmem_flush, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch flush and memory freeze with a
// remembered flush. Define HAZARD_STATS_EN to build the stall/flush counters.
module hazard_unit (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN          = 2'b00,
    FREEZE       = 2'b01,
    FREEZE_FLUSH = 2'b10
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic load_use_s;
  logic pc_write_s;
  logic ifid_write_s;
  logic idex_write_s;
  logic exmem_write_s;
  logic ctrl_enable_s;
  logic flush_s;

  function automatic logic detect_load_use(input logic memread, input logic [4:0] ld_rt,
                                           input logic [4:0] rs, input logic [4:0] rt);
    return memread && (ld_rt != 5'd0) && ((ld_rt == rs) || (ld_rt == rt));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? 16'hFFFF : value + 16'd1;
  endfunction

  assign load_use_s = detect_load_use(hz.idex_memread, hz.idex_rt, hz.ifid_rs, hz.ifid_rt);

  // State register; FREEZE_FLUSH doubles as the pending-flush flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: a busy memory holds the pipeline and remembers any branch seen
  always_comb begin
    state_next_s = RUN;
    if (hz.mem_busy) begin
      if (hz.branch_taken || (state_r == FREEZE_FLUSH)) begin
        state_next_s = FREEZE_FLUSH;
      end else begin
        state_next_s = FREEZE;
      end
    end else begin
      state_next_s = RUN;
    end
  end

  // Mealy outputs from state and current inputs
  always_comb begin
    pc_write_s    = 1'b0;
    ifid_write_s  = 1'b0;
    idex_write_s  = 1'b0;
    exmem_write_s = 1'b0;
    ctrl_enable_s = 1'b0;
    flush_s       = 1'b0;
    if (reset) begin
      pc_write_s    = 1'b0;
    end else if (hz.mem_busy) begin
      ctrl_enable_s = 1'b1;
    end else begin
      case (state_r)
        FREEZE_FLUSH: begin
          // a branch arriving now merges into the flush already owed
          pc_write_s    = 1'b1;
          ifid_write_s  = 1'b1;
          idex_write_s  = 1'b1;
          exmem_write_s = 1'b1;
          ctrl_enable_s = 1'b1;
          flush_s       = 1'b1;
        end
        default: begin
          // RUN, FREEZE release cycle and the unused code all act as RUN
          if (hz.branch_taken) begin
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            idex_write_s  = 1'b1;
            exmem_write_s = 1'b1;
            ctrl_enable_s = 1'b1;
            flush_s       = 1'b1;
          end else if (load_use_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_write_s  = 1'b1;
            exmem_write_s = 1'b1;
            ctrl_enable_s = 1'b0;
          end else begin
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            idex_write_s  = 1'b1;
            exmem_write_s = 1'b1;
            ctrl_enable_s = 1'b1;
          end
        end
      endcase
    end
  end

  assign hz.pc_write    = pc_write_s;
  assign hz.ifid_write  = ifid_write_s;
  assign hz.idex_write  = idex_write_s;
  assign hz.exmem_write = exmem_write_s;
  assign hz.ctrl_enable = ctrl_enable_s;
  assign hz.ifid_flush  = flush_s;
  assign hz.idex_flush  = flush_s;
  assign hz.exmem_flush = flush_s;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count_r;
  logic [15:0] flush_count_r;

  // Saturating statistics counters, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_r <= 16'h0000;
      flush_count_r <= 16'h0000;
    end else begin
      if (!pc_write_s) begin
        stall_count_r <= sat_inc(stall_count_r);
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (flush_s) begin
        flush_count_r <= sat_inc(flush_count_r);
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign hz.stall_count = stall_count_r;
  assign hz.flush_count = flush_count_r;
`else
  assign hz.stall_count = sat_inc(16'hFFFF) & 16'h0000;
  assign hz.flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; expected output vectors are hand-computed.
module tb_hazard_unit;

  logic clk;
  logic reset;
  hazard_unit_if hz ();

  hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // {pc, ifid, idex, exmem, ctrl, ifid_flush, idex_flush, exmem_flush}
  localparam logic [7:0] V_RST   = 8'b0000_0000;
  localparam logic [7:0] V_NOM   = 8'b1111_1000;
  localparam logic [7:0] V_STALL = 8'b0011_0000;
  localparam logic [7:0] V_FLUSH = 8'b1111_1111;
  localparam logic [7:0] V_FRZ   = 8'b0000_1000;

  int checks;
  int errors;
  logic [15:0] exp_stall;
  logic [15:0] exp_flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ld_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic busy);
    hz.idex_memread = mr;
    hz.idex_rt      = ld_rt;
    hz.ifid_rs      = rs;
    hz.ifid_rt      = rt;
    hz.branch_taken = br;
    hz.mem_busy     = busy;
  endtask

  // check outputs mid-cycle, then advance one clock while tracking counters
  task automatic cycle(input string tag, input logic [7:0] exp, input bit do_check);
    @(negedge clk);
    if (do_check) begin
      check_val(tag, {8'h00, hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
                      hz.ctrl_enable, hz.ifid_flush, hz.idex_flush, hz.exmem_flush},
                {8'h00, exp});
    end
    if (reset) begin
      exp_stall = 16'h0000;
      exp_flush = 16'h0000;
    end else begin
      if (!exp[7] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (exp[2] && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_stall"}, hz.stall_count, STATS ? exp_stall : 16'h0000);
    check_val({tag, "_flush"}, hz.flush_count, STATS ? exp_flush : 16'h0000);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_stall = 16'h0000;
    exp_flush = 16'h0000;
    reset     = 1'b1;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cycle("reset_outputs", V_RST, 1'b1);
    check_counts("reset");

    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("first_run", V_NOM, 1'b1);

    // load-use on rs, then on rt, then non-hazards
    drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0);
    cycle("lu_rs", V_STALL, 1'b1);
    drive(1'b0, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0);
    cycle("lu_rs_after", V_NOM, 1'b1);
    drive(1'b1, 5'd6, 5'd2, 5'd6, 1'b0, 1'b0);
    cycle("lu_rt", V_STALL, 1'b1);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("lu_r0", V_NOM, 1'b1);
    drive(1'b1, 5'd3, 5'd4, 5'd2, 1'b0, 1'b0);
    cycle("lu_nomatch", V_NOM, 1'b1);
    drive(1'b0, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0);
    cycle("no_memread", V_NOM, 1'b1);

    // branch beats load-use
    drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0);
    cycle("br_over_lu", V_FLUSH, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("br_after", V_NOM, 1'b1);
    check_counts("mid");

    // freeze 4 cycles, branch in cycle 2, flushed on release
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle("frz1", V_FRZ, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle("frz2_br", V_FRZ, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle("frz3", V_FRZ, 1'b1);
    cycle("frz4", V_FRZ, 1'b1);
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    cycle("frz_release_flush", V_FLUSH, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("frz_after", V_NOM, 1'b1);

    // plain freeze, release with load-use on r9
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("frz_plain", V_FRZ, 1'b1);
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
    cycle("frz_release_lu", V_STALL, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("frz_release_lu_after", V_NOM, 1'b1);

    // plain freeze, branch in release cycle acts as RUN
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle("frz_b", V_FRZ, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    cycle("frz_release_br", V_FLUSH, 1'b1);

    // pending flush merges with branch at release; no second flush
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle("ff_enter", V_FRZ, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle("ff_hold", V_FRZ, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    cycle("ff_merge", V_FLUSH, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("ff_no_second", V_NOM, 1'b1);
    check_counts("pre_reset");

    // reset discards a pending flush
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    cycle("ff_enter2", V_FRZ, 1'b1);
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("reset_in_ff", V_RST, 1'b1);
    reset = 1'b0;
    check_counts("after_reset");
    cycle("ff_discarded", V_NOM, 1'b1);

    // long freeze saturates the stall counter
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 70000; i++) cycle("sat", V_FRZ, 1'b0);
    check_counts("saturate");
    check_val("sat_value", hz.stall_count, STATS ? 16'hFFFF : 16'h0000);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle("sat_release", V_NOM, 1'b1);
    check_counts("sat_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
